mem_wb_stage: RTL

- Memory-access and writeback stage of the five-stage MIPS pipeline.
- Consumes EX/MEM latch outputs and resolves the branch decision back to i_fetch (EX_MEM_PCSrc, EX_MEM_NPC).
- Performs data-memory load/store and holds the MEM/WB pipeline register.
- Drives the writeback mux result and register-write control back to i_decode (MEM_WB_rd, MEM_WB_regwrite, WB_mux5_writedata).

---
 rtl/mem_wb_stage.sv | 77 +++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: branch resolve, data memory access, MEM/WB register and
// writeback mux feeding the decode stage.
module mem_wb_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_MEM_branch,
  input  logic        EX_MEM_zero,
  input  logic [31:0] EX_MEM_target,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_memtoreg,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_rdata2,
  input  logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_PCSrc,
  output logic [31:0] EX_MEM_NPC,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic [31:0] WB_mux5_writedata,
  output logic        mem_fault
);

  logic [31:0]       r_mem [DEPTH];
  logic [4:0]        r_rd;
  logic              r_regwrite;
  logic              r_memtoreg;
  logic [31:0]       r_rdata;
  logic [31:0]       r_alu;
  logic              r_fault;

  logic [ADDR_W-1:0] w_idx;
  logic              w_aligned;
  logic              w_misacc;
  logic [31:0]       w_rdata;

  assign EX_MEM_PCSrc = EX_MEM_branch & EX_MEM_zero;
  assign EX_MEM_NPC   = EX_MEM_target;

  assign w_idx     = EX_MEM_alu_result[ADDR_W+1:2];
  assign w_aligned = (EX_MEM_alu_result[1:0] == 2'b00);
  assign w_misacc  = (EX_MEM_memread | EX_MEM_memwrite) & ~w_aligned;
  assign w_rdata   = (EX_MEM_memread && w_aligned) ? r_mem[w_idx] : '0;

  // Array contents survive reset; only the write is blocked while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && EX_MEM_memwrite && w_aligned)
      r_mem[w_idx] <= EX_MEM_rdata2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_rdata    <= '0;
      r_alu      <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_rd       <= EX_MEM_rd;
      r_regwrite <= EX_MEM_regwrite;
      r_memtoreg <= EX_MEM_memtoreg;
      r_rdata    <= w_rdata;
      r_alu      <= EX_MEM_alu_result;
      r_fault    <= r_fault | w_misacc;
    end
  end

  assign MEM_WB_rd         = r_rd;
  assign MEM_WB_regwrite   = r_regwrite & (r_rd != 5'd0);
  assign WB_mux5_writedata = r_memtoreg ? r_rdata : r_alu;
  assign mem_fault         = r_fault;

endmodule
